score_keeper: RTL

Match-score source for the air-hockey display path. Detects goal events from the puck/field logic and keeps each player's score as BCD digits (ones 0–9, tens 0–7). The digits drive the seven-segment display block's `p1_ones`/`p1_tens`/`p2_ones`/`p2_tens` inputs. The block also sequences goal pauses and end-of-game, and freezes play through the `freeze` output.

---
 rtl/score_keeper.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper
//   Detects goal events from the puck/field logic and keeps each player's
//   score as BCD digits for the seven-segment display. It also sequences the
//   pause after each goal and the end of the match.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   p1_goal    in   level, high while the puck sits in player 2's goal
//   p2_goal    in   level, high while the puck sits in player 1's goal
//   new_game   in   one-cycle request to restart the match
//   p1_ones    out  player 1 score, BCD ones digit
//   p1_tens    out  player 1 score, tens digit
//   p2_ones    out  player 2 score, BCD ones digit
//   p2_tens    out  player 2 score, tens digit
//   freeze     out  high while the puck must be held (HOLD or OVER)
//   scorer     out  during HOLD: 01 = P1 scored last, 10 = P2
//   game_over  out  high in OVER
//   winner     out  in OVER: 01 = P1 won, 10 = P2 won
module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int HOLD_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1_goal,
  input  logic       p2_goal,
  input  logic       new_game,
  output logic [3:0] p1_ones,
  output logic [2:0] p1_tens,
  output logic [3:0] p2_ones,
  output logic [2:0] p2_tens,
  output logic       freeze,
  output logic [1:0] scorer,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

  state_t            state, state_nx;
  logic              p1_goal_q, p2_goal_q;
  logic              p1_rise, p2_rise;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
  logic [6:0]        p1_nx, p2_nx;
  logic [6:0]        p1_inc, p2_inc;
  logic [1:0]        scorer_nx, winner_nx;

  // Score digits are handled as one packed {tens[2:0], ones[3:0]} value.
  function automatic logic [6:0] bcd_inc(input logic [6:0] d);
    logic [6:0] r;
    if (d[3:0] == 4'd9) r = {d[6:4] + 3'd1, 4'd0};
    else                r = {d[6:4], d[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic is_win(input logic [6:0] d);
    logic [6:0] val;
    val = ({4'd0, d[6:4]} * 7'd10) + {3'd0, d[3:0]};
    return (val == 7'(WIN_SCORE));
  endfunction

  assign p1_rise = p1_goal & ~p1_goal_q;
  assign p2_rise = p2_goal & ~p2_goal_q;
  assign p1_inc  = bcd_inc({p1_tens, p1_ones});
  assign p2_inc  = bcd_inc({p2_tens, p2_ones});

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    p1_nx       = {p1_tens, p1_ones};
    p2_nx       = {p2_tens, p2_ones};
    scorer_nx   = scorer;
    winner_nx   = winner;
    if (new_game) begin
      // Restart wins over any goal edge seen in the same cycle.
      state_nx    = PLAY;
      hold_cnt_nx = '0;
      p1_nx       = '0;
      p2_nx       = '0;
      scorer_nx   = 2'b00;
      winner_nx   = 2'b00;
    end else begin
      case (state)
        PLAY: begin
          // Simultaneous rises are a field glitch and score nothing.
          if (p1_rise && !p2_rise) begin
            p1_nx = p1_inc;
            if (is_win(p1_inc)) begin
              state_nx  = OVER;
              winner_nx = 2'b01;
            end else begin
              state_nx    = HOLD;
              scorer_nx   = 2'b01;
              hold_cnt_nx = '0;
            end
          end else if (p2_rise && !p1_rise) begin
            p2_nx = p2_inc;
            if (is_win(p2_inc)) begin
              state_nx  = OVER;
              winner_nx = 2'b10;
            end else begin
              state_nx    = HOLD;
              scorer_nx   = 2'b10;
              hold_cnt_nx = '0;
            end
          end
        end
        HOLD: begin
          hold_cnt_nx = hold_cnt + 1'b1;
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_nx  = PLAY;
            scorer_nx = 2'b00;
          end
        end
        OVER: ;
        default: state_nx = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PLAY;
      hold_cnt  <= '0;
      p1_goal_q <= 1'b0;
      p2_goal_q <= 1'b0;
      p1_ones   <= '0;
      p1_tens   <= '0;
      p2_ones   <= '0;
      p2_tens   <= '0;
      scorer    <= 2'b00;
      winner    <= 2'b00;
      freeze    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_cnt_nx;
      // History follows the inputs in every state so a level still high
      // when a pause ends cannot score again.
      p1_goal_q <= p1_goal;
      p2_goal_q <= p2_goal;
      {p1_tens, p1_ones} <= p1_nx;
      {p2_tens, p2_ones} <= p2_nx;
      scorer    <= scorer_nx;
      winner    <= winner_nx;
      freeze    <= (state_nx != PLAY);
      game_over <= (state_nx == OVER);
    end
  end

endmodule
